// File: rtl/deinterleave_ctrl_if.sv
// Handshake and datapath bundle between the deinterleave controller, the
// demapper and Viterbi stream endpoints, and the deinterleaver datapath.
interface deinterleave_ctrl_if #(
   parameter int NMAX = 288
);
   logic [1:0]      rate;
   logic            in_valid;
   logic            in_bit;
   logic            in_ready;
   logic [NMAX-1:0] dil_m;
   logic [8:0]      dil_ncbps;
   logic [NMAX-1:0] dil_out;
   logic            out_valid;
   logic            out_bit;
   logic            out_last;
   logic            out_ready;
   logic            sym_done;

   // Controller side
   modport slave (
      input  rate, in_valid, in_bit, dil_out, out_ready,
      output in_ready, dil_m, dil_ncbps, out_valid, out_bit, out_last, sym_done
   );

   // Environment side: demapper, datapath and downstream decoder
   modport master (
      output rate, in_valid, in_bit, dil_out, out_ready,
      input  in_ready, dil_m, dil_ncbps, out_valid, out_bit, out_last, sym_done
   );
endinterface

// File: rtl/deinterleave_ctrl.sv
// Per-symbol sequencer for the block deinterleaver: packs serial coded bits into
// the symbol buffer, waits out the datapath latency, then streams the result.
module deinterleave_ctrl #(
   parameter int NMAX = 288,
   parameter int LAT  = 1
) (
   input  logic               clk,
   input  logic               reset,
   deinterleave_ctrl_if.slave bus
);

   localparam int              WCW   = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [WCW-1:0]  LAT_W = WCW'(LAT);

   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   localparam logic [1:0] O_IDLE  = 2'd0;
   localparam logic [1:0] O_WAIT  = 2'd1;
   localparam logic [1:0] O_DRAIN = 2'd2;

   function automatic logic [8:0] rate_to_ncbps(input logic [1:0] r);
      case (r)
         2'd0:    return 9'd48;
         2'd1:    return 9'd96;
         2'd2:    return 9'd192;
         default: return 9'd288;
      endcase
   endfunction

   logic [0:0]      r_istate;
   logic [8:0]      r_icnt;
   logic [NMAX-1:0] r_dil_m;
   logic [8:0]      r_dil_ncbps;

   logic [1:0]      r_ostate;
   logic [WCW-1:0]  r_wcnt;
   logic [8:0]      r_ocnt;
   logic [NMAX-1:0] r_obuf;
   logic [8:0]      r_oncbps;
   logic            r_out_valid;
   logic            r_out_bit;
   logic            r_out_last;
   logic            r_sym_done;

   logic            w_in_acc;
   logic            w_capture;
   logic [8:0]      w_ncbps_eff;
   logic [8:0]      w_ocnt_nxt;

   // NOTE: in_ready is gated by reset combinationally so no bit is offered
   // acceptance while reset is held, even though the state register is FILL.
   assign bus.in_ready = (r_istate == S_FILL) && !reset;
   assign w_in_acc     = bus.in_valid && bus.in_ready;
   assign w_capture    = (r_ostate == O_WAIT) && (r_wcnt == LAT_W);

   // The first bit of a symbol decides its length before dil_ncbps is updated.
   assign w_ncbps_eff  = (r_icnt == 9'd0) ? rate_to_ncbps(bus.rate) : r_dil_ncbps;
   assign w_ocnt_nxt   = r_ocnt + 9'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_istate    <= S_FILL;
         r_icnt      <= '0;
         r_dil_m     <= '0;
         r_dil_ncbps <= '0;
      end else begin
         case (r_istate)
            S_FILL: begin
               if (w_in_acc) begin
                  r_dil_m[r_icnt] <= bus.in_bit;
                  if (r_icnt == 9'd0) begin
                     r_dil_ncbps <= w_ncbps_eff;
                  end
                  if (r_icnt == w_ncbps_eff - 9'd1) begin
                     r_istate <= S_FULL;
                     r_icnt   <= '0;
                  end else begin
                     r_icnt   <= r_icnt + 9'd1;
                  end
               end
            end
            default: begin
               if (w_capture) begin
                  r_istate <= S_FILL;
                  r_dil_m  <= '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ostate    <= O_IDLE;
         r_wcnt      <= '0;
         r_ocnt      <= '0;
         r_obuf      <= '0;
         r_oncbps    <= '0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_last  <= 1'b0;
         r_sym_done  <= 1'b0;
      end else begin
         r_sym_done <= 1'b0;
         case (r_ostate)
            O_IDLE: begin
               if (r_istate == S_FULL) begin
                  r_ostate <= O_WAIT;
                  r_wcnt   <= '0;
               end
            end
            O_WAIT: begin
               if (w_capture) begin
                  r_obuf      <= bus.dil_out;
                  r_oncbps    <= r_dil_ncbps;
                  r_ocnt      <= '0;
                  r_out_valid <= 1'b1;
                  r_out_bit   <= bus.dil_out[0];
                  r_out_last  <= (r_dil_ncbps == 9'd1);
                  r_ostate    <= O_DRAIN;
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            O_DRAIN: begin
               if (r_out_valid && bus.out_ready) begin
                  if (r_out_last) begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_sym_done  <= 1'b1;
                     r_ostate    <= O_IDLE;
                  end else begin
                     r_ocnt      <= w_ocnt_nxt;
                     r_out_bit   <= r_obuf[w_ocnt_nxt];
                     r_out_last  <= (w_ocnt_nxt == r_oncbps - 9'd1);
                  end
               end
            end
            default: r_ostate <= O_IDLE;
         endcase
      end
   end

   assign bus.dil_m     = r_dil_m;
   assign bus.dil_ncbps = r_dil_ncbps;
   assign bus.out_valid = r_out_valid;
   assign bus.out_bit   = r_out_bit;
   assign bus.out_last  = r_out_last;
   assign bus.sym_done  = r_sym_done;

endmodule

// File: tb/tb_deinterleave_ctrl.sv
// Bench for deinterleave_ctrl: rate-decode vector table, directed corner-case
// sequences, and randomized symbols scored against a bit-permutation model.
module tb_deinterleave_ctrl;

   localparam int NMAX = 288;
   localparam int LAT  = 1;

   typedef struct {
      logic [1:0] rate;
      logic       bit0;
      int         exp_ncbps;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   deinterleave_ctrl_if #(.NMAX(NMAX)) bus ();

   deinterleave_ctrl #(.NMAX(NMAX), .LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int nc_tab [4] = '{48, 96, 192, 288};

   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stand-in: one register stage, bit i of the buffer lands at 16i-(N-1)*floor(16i/N)
   function automatic logic [NMAX-1:0] dp_model(input logic [NMAX-1:0] m, input logic [8:0] nc);
      logic [NMAX-1:0] r;
      int n;
      r = '0;
      n = int'(nc);
      for (int i = 0; i < n && i < NMAX; i++) r[16*i - (n-1)*((16*i)/n)] = m[i];
      return r;
   endfunction

   always @(posedge clk) bus.dil_out <= dp_model(bus.dil_m, bus.dil_ncbps);

   // Output monitor
   bit   got_q[$];
   bit   exp_q[$];
   int   lastidx_q[$];
   int   lastcyc_q[$];
   int   rise_q[$];
   int   sym_done_cnt = 0;
   int   hold_err     = 0;
   int   overlap      = 0;
   logic prev_valid   = 1'b0;
   logic prev_stall   = 1'b0;
   logic prev_bit     = 1'b0;
   logic prev_last    = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_stall && !(bus.out_valid === 1'b1 && bus.out_bit === prev_bit &&
                             bus.out_last === prev_last)) hold_err++;
         if (bus.out_valid === 1'b1 && !prev_valid) rise_q.push_back(cyc);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got_q.push_back(bus.out_bit);
            if (bus.out_last === 1'b1) begin
               lastidx_q.push_back(got_q.size() - 1);
               lastcyc_q.push_back(cyc);
            end
         end
         if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1) overlap++;
         if (bus.sym_done === 1'b1) sym_done_cnt++;
      end
      prev_valid = !reset && (bus.out_valid === 1'b1);
      prev_stall = !reset && (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      prev_bit   = bus.out_bit;
      prev_last  = bus.out_last;
   end

   // Downstream ready: 0 = always, 1 = toggle, 2 = random ~75%
   int rdy_mode = 0;
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = ($urandom_range(3, 0) != 0);
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required completion before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      lastidx_q.delete();
      lastcyc_q.delete();
      rise_q.delete();
      sym_done_cnt = 0;
      hold_err     = 0;
      overlap      = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      clear_mon();
   endtask

   function automatic logic [NMAX-1:0] rand_bits();
      logic [NMAX-1:0] d;
      for (int i = 0; i < NMAX; i++) d[i] = 1'($urandom);
      return d;
   endfunction

   // Reference: output index k carries the input bit at the 802.11 interleaver position of k
   task automatic push_expected(input logic [NMAX-1:0] data, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(data[(n/16)*(k%16) + k/16]);
   endtask

   int last_in_cyc = 0;

   // Called at posedge+1; returns at posedge+1 after the last bit is consumed
   task automatic send_symbol(input logic [NMAX-1:0] data, input int n, input logic [1:0] r,
                              input int chg_at, input logic [1:0] r2);
      for (int i = 0; i < n; i++) begin
         int k;
         k = 0;
         bus.rate     = (chg_at >= 0 && i > chg_at) ? r2 : r;
         bus.in_valid = 1'b1;
         bus.in_bit   = data[i];
         forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            k++;
            if (k > 4000) begin
               check("in_ready_timeout", 0, 1);
               bus.in_valid = 1'b0;
               return;
            end
            @(posedge clk);
            #1;
         end
         last_in_cyc = cyc;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_outputs(input int n, input string name);
      int k;
      k = 0;
      while (got_q.size() < n && k < 10000) begin
         @(negedge clk);
         k++;
      end
      repeat (6) @(negedge clk);
      check(name, got_q.size(), n);
   endtask

   task automatic compare_exp(input string name);
      int errs;
      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) errs++;
      check(name, errs, 0);
   endtask

   initial begin
      vec_t            vecs [4];
      logic [NMAX-1:0] d1;
      logic [NMAX-1:0] d2;
      int              total;
      int              r;

      bus.rate     = 2'd0;
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b0;

      // Reset held with in_valid asserted
      repeat (3) @(negedge clk);
      check("rst_in_ready",  bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last",  bus.out_last, 0);
      check("rst_sym_done",  bus.sym_done, 0);
      check("rst_dil_ncbps", bus.dil_ncbps, 0);
      check("rst_dil_m",     $countones(bus.dil_m), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_release_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;

      // Rate decode table: one bit per fresh symbol, then inspect the buffer
      vecs[0] = '{2'd0, 1'b1, 48};
      vecs[1] = '{2'd1, 1'b0, 96};
      vecs[2] = '{2'd2, 1'b1, 192};
      vecs[3] = '{2'd3, 1'b1, 288};
      for (int v = 0; v < 4; v++) begin
         do_reset();
         d1    = '0;
         d1[0] = vecs[v].bit0;
         send_symbol(d1, 1, vecs[v].rate, -1, 2'd0);
         @(negedge clk);
         check("vec_ncbps",     bus.dil_ncbps, vecs[v].exp_ncbps);
         check("vec_dil_m0",    bus.dil_m[0], vecs[v].bit0);
         check("vec_dil_ones",  $countones(bus.dil_m), vecs[v].bit0);
         check("vec_in_ready",  bus.in_ready, 1);
         check("vec_out_valid", bus.out_valid, 0);
      end

      // rate=0, one-hot at input bit 1
      do_reset();
      rdy_mode = 0;
      d1    = '0;
      d1[1] = 1'b1;
      push_expected(d1, 48);
      send_symbol(d1, 48, 2'd0, -1, 2'd0);
      wait_outputs(48, "t2_count");
      compare_exp("t2_data");
      check("t2_bit16", got_q[16], 1);
      total = 0;
      foreach (got_q[i]) total += int'(got_q[i]);
      check("t2_ones", total, 1);
      check("t2_last_cnt", lastidx_q.size(), 1);
      if (lastidx_q.size() > 0) check("t2_last_idx", lastidx_q[0], 47);
      check("t2_sym_done", sym_done_cnt, 1);
      check("t2_rise_cnt", rise_q.size(), 1);
      if (rise_q.size() > 0) check("t2_latency", rise_q[0] - last_in_cyc, LAT + 3);

      // rate=3, two back-to-back symbols
      do_reset();
      d1 = rand_bits();
      d2 = rand_bits();
      push_expected(d1, 288);
      push_expected(d2, 288);
      send_symbol(d1, 288, 2'd3, -1, 2'd0);
      send_symbol(d2, 288, 2'd3, -1, 2'd0);
      wait_outputs(576, "t3_count");
      compare_exp("t3_data");
      check("t3_last_cnt", lastidx_q.size(), 2);
      if (lastidx_q.size() == 2) begin
         check("t3_last0", lastidx_q[0], 287);
         check("t3_last1", lastidx_q[1], 575);
      end
      check("t3_sym_done", sym_done_cnt, 2);
      check("t3_overlap", overlap > 100, 1);
      if (rise_q.size() == 2 && lastcyc_q.size() == 2)
         check("t3_gap", (rise_q[1] - lastcyc_q[0] - 1) <= LAT + 3, 1);
      else
         check("t3_gap_seen", rise_q.size() * 10 + lastcyc_q.size(), 22);

      // rate=1 with toggling out_ready
      do_reset();
      rdy_mode = 1;
      d1 = rand_bits();
      push_expected(d1, 96);
      send_symbol(d1, 96, 2'd1, -1, 2'd0);
      wait_outputs(96, "t4_count");
      compare_exp("t4_data");
      check("t4_hold", hold_err, 0);
      check("t4_sym_done", sym_done_cnt, 1);
      if (lastidx_q.size() > 0) check("t4_last_idx", lastidx_q[0], 95);
      else check("t4_last_seen", lastidx_q.size(), 1);
      rdy_mode = 0;

      // rate change mid-symbol is ignored until the next symbol
      do_reset();
      d1 = rand_bits();
      d2 = rand_bits();
      push_expected(d1, 48);
      push_expected(d2, 288);
      send_symbol(d1, 48, 2'd0, 10, 2'd3);
      @(negedge clk);
      check("t5_ncbps_latched", bus.dil_ncbps, 48);
      @(posedge clk);
      #1;
      send_symbol(d2, 288, 2'd3, -1, 2'd0);
      wait_outputs(336, "t5_count");
      compare_exp("t5_data");
      check("t5_last_cnt", lastidx_q.size(), 2);
      if (lastidx_q.size() == 2) begin
         check("t5_last0", lastidx_q[0], 47);
         check("t5_last1", lastidx_q[1], 335);
      end

      // Reset in the middle of a 192-bit drain
      do_reset();
      d1 = rand_bits();
      send_symbol(d1, 192, 2'd2, -1, 2'd0);
      total = 0;
      while (got_q.size() < 100 && total < 5000) begin
         @(negedge clk);
         total++;
      end
      check("t6_reached_100", got_q.size() >= 100, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_out_valid", bus.out_valid, 0);
      check("t6_out_last",  bus.out_last, 0);
      check("t6_in_ready",  bus.in_ready, 0);
      check("t6_dil_m",     $countones(bus.dil_m), 0);
      check("t6_dil_ncbps", bus.dil_ncbps, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_mon();
      d2 = rand_bits();
      push_expected(d2, 48);
      send_symbol(d2, 48, 2'd0, -1, 2'd0);
      wait_outputs(48, "t6_count");
      compare_exp("t6_data");
      check("t6_sym_done", sym_done_cnt, 1);
      if (lastidx_q.size() > 0) check("t6_last_idx", lastidx_q[0], 47);
      else check("t6_last_seen", lastidx_q.size(), 1);

      // Randomized symbols, random rates and random back-pressure
      do_reset();
      rdy_mode = 2;
      total    = 0;
      for (int s = 0; s < 5; s++) begin
         r  = $urandom_range(3, 0);
         d1 = rand_bits();
         push_expected(d1, nc_tab[r]);
         total += nc_tab[r];
         send_symbol(d1, nc_tab[r], 2'(r), -1, 2'd0);
      end
      wait_outputs(total, "rnd_count");
      compare_exp("rnd_data");
      check("rnd_sym_done", sym_done_cnt, 5);
      check("rnd_last_cnt", lastidx_q.size(), 5);
      check("rnd_hold", hold_err, 0);
      rdy_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
